// File: rtl/clk_div_n.sv
// clk_div_n: run-time programmable divide-by-N clock divider (N >= 2).
// Produces a 50% duty clk_o for even and odd N, a period-start strobe
// in the source domain, and applies divisor changes and stop requests
// only at output-period boundaries so clk_o never glitches.
module clk_div_n #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div,
    input  logic             div_load,
    output logic             clk_o,
    output logic             tick,
    output logic             running,
    output logic             div_err,
    output logic [WIDTH-1:0] cur_div
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
    localparam logic [WIDTH:0]   ONE_H   = (WIDTH + 1)'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] n_act;
    logic [WIDTH-1:0] n_pend;
    logic             h_p;
    logic             h_n;
    logic [WIDTH:0]   half;
    logic             wrap;

    // Half period H = ceil(n/2), one bit wider so N = 2^WIDTH-1 cannot overflow.
    function automatic logic [WIDTH:0] half_len(input logic [WIDTH-1:0] n);
        half_len = ({1'b0, n} + ONE_H) >> 1;
    endfunction

    assign half = half_len(n_act);
    assign wrap = (cnt == (n_act - ONE_W));

    // Period sequencer: start on en, count positions, swap divisor and honour stop at the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            n_act <= DEF_DIV;
            h_p   <= 1'b0;
            tick  <= 1'b0;
        end else if (state == S_IDLE) begin
            cnt  <= '0;
            h_p  <= 1'b0;
            tick <= 1'b0;
            if (en) begin
                state <= S_RUN;
                n_act <= n_pend;
            end
        end else begin
            h_p  <= ({1'b0, cnt} < half);
            tick <= (cnt == '0);
            if (wrap) begin
                cnt   <= '0;
                n_act <= n_pend;
                if (!en) begin
                    state <= S_IDLE;
                    h_p   <= 1'b0;
                end
            end else begin
                cnt <= cnt + ONE_W;
            end
        end
    end

    // Divisor load port: accept N >= 2 into the pending slot, flag anything smaller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_pend  <= DEF_DIV;
            div_err <= 1'b0;
        end else begin
            div_err <= div_load && (div < MIN_DIV);
            if (div_load && (div >= MIN_DIV)) begin
                n_pend <= div;
            end
        end
    end

    // Half-cycle delayed copy of the phase flop; trims the odd-N high phase by half a cycle.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            h_n <= 1'b0;
        end else begin
            h_n <= h_p;
        end
    end

    // n_act only changes while h_p is low, so the parity select cannot glitch clk_o.
    assign clk_o   = n_act[0] ? (h_p & h_n) : h_p;
    assign running = (state == S_RUN);
    assign cur_div = n_act;

endmodule

// File: tb/tb_clk_div_n.sv
// Testbench for clk_div_n: period-level reference model, randomized and directed scenarios.
module tb_clk_div_n;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             div_load;
    logic [WIDTH-1:0] div;
    logic             clk_o;
    logic             tick;
    logic             running;
    logic             div_err;
    logic [WIDTH-1:0] cur_div;

    int total = 0;
    int bad   = 0;

    clk_div_n #(.WIDTH(WIDTH), .DEFAULT_DIV(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div     (div),
        .div_load(div_load),
        .clk_o   (clk_o),
        .tick    (tick),
        .running (running),
        .div_err (div_err),
        .cur_div (cur_div)
    );

    always #5 clk = ~clk;

    // Reference model: which output period is running, its length, and the position in it.
    bit m_run;
    int m_j;
    int m_n;
    int m_pend;
    bit e_tick, e_run, e_err, e_clk_p, e_clk_n;
    logic [WIDTH-1:0] e_cur;
    logic o_tick, o_run, o_err, o_clk_p, o_clk_n;
    logic [WIDTH-1:0] o_cur;

    // clk_o level in half-cycle h (0 = just after the period-start edge) of an N-cycle period:
    // N high half-cycles, starting at once for even N, half a cycle late for odd N.
    function automatic bit hi_half(input int n, input int h);
        if (n % 2 == 0) return (h < n);
        return (h >= 1) && (h <= n);
    endfunction

    function automatic logic [13:0] got_v();
        return {o_clk_p, o_clk_n, o_tick, o_run, o_err, o_cur};
    endfunction

    function automatic logic [13:0] exp_v();
        return {e_clk_p, e_clk_n, e_tick, e_run, e_err, e_cur};
    endfunction

    task automatic m_reset();
        m_run  = 1'b0;
        m_j    = -1;
        m_n    = 3;
        m_pend = 3;
        e_tick = 0; e_run = 0; e_err = 0; e_clk_p = 0; e_clk_n = 0;
        e_cur  = WIDTH'(3);
    endtask

    task automatic model_step(input int en_i, input int load_i, input int div_i);
        bit out_valid;
        int out_n;
        int out_j;
        out_valid = 0;
        out_n = 0;
        out_j = 0;
        e_err = (load_i != 0) && (div_i < 2);
        if (!m_run) begin
            if (en_i != 0) begin
                m_run = 1'b1;
                m_n   = m_pend;
                m_j   = -1;
            end
        end else begin
            m_j = m_j + 1;
            out_valid = 1;
            out_n = m_n;
            out_j = m_j;
            if (m_j == m_n - 1) begin
                m_n = m_pend;
                m_j = -1;
                if (en_i == 0) m_run = 1'b0;
            end
        end
        if ((load_i != 0) && (div_i >= 2)) m_pend = div_i;
        e_tick  = out_valid && (out_j == 0);
        e_run   = m_run;
        e_cur   = WIDTH'(m_n);
        e_clk_p = out_valid && hi_half(out_n, 2 * out_j);
        e_clk_n = out_valid && hi_half(out_n, 2 * out_j + 1);
    endtask

    // One source cycle: model the edge, sample after the rising and after the falling edge.
    task automatic advance();
        @(posedge clk);
        model_step(int'(en), int'(div_load), int'(div));
        #2;
        o_tick  = tick;
        o_run   = running;
        o_err   = div_err;
        o_cur   = cur_div;
        o_clk_p = clk_o;
        @(negedge clk);
        #2;
        o_clk_n = clk_o;
    endtask

    // Assumes a tick was just observed; runs to the next tick, returning cycles and high half-cycles.
    task automatic measure_period(output int cyc, output int hi);
        hi  = int'(o_clk_p) + int'(o_clk_n);
        cyc = 0;
        for (int i = 0; i < 600; i++) begin
            advance();
            cyc++;
            if (o_tick) return;
            hi += int'(o_clk_p) + int'(o_clk_n);
        end
        cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; div_load = 1'b0; div = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #2;
        total++; if (clk_o !== 1'b0)   begin bad++; $display("FAIL reset_clk_o got=%b want=0", clk_o); end
        total++; if (tick !== 1'b0)    begin bad++; $display("FAIL reset_tick got=%b want=0", tick); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b want=0", running); end
        total++; if (div_err !== 1'b0) begin bad++; $display("FAIL reset_div_err got=%b want=0", div_err); end
        total++; if (cur_div !== 8'd3) begin bad++; $display("FAIL reset_cur_div got=%0d want=3", cur_div); end
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_default_run();
        int hc;
        int tc;
        en = 1'b1;
        hc = 0;
        tc = 0;
        advance();
        total++; if (got_v() !== exp_v()) begin bad++; $display("FAIL default_start got=%b want=%b", got_v(), exp_v()); end
        for (int i = 0; i < 12; i++) begin
            advance();
            total++; if (got_v() !== exp_v()) begin bad++; $display("FAIL default_cyc%0d got=%b want=%b", i, got_v(), exp_v()); end
            hc += int'(o_clk_p) + int'(o_clk_n);
            tc += int'(o_tick);
        end
        total++; if (tc != 4)  begin bad++; $display("FAIL default_ticks got=%0d want=4", tc); end
        total++; if (hc != 12) begin bad++; $display("FAIL default_high_halves got=%0d want=12", hc); end
    endtask

    task automatic test_load_mid_period();
        int cyc;
        int hi;
        for (int i = 0; i < 10 && !o_tick; i++) advance();
        div = 8'd4; div_load = 1'b1;
        advance();
        div_load = 1'b0;
        total++; if (o_cur !== 8'd3) begin bad++; $display("FAIL load4_before_wrap got=%0d want=3", o_cur); end
        total++; if (got_v() !== exp_v()) begin bad++; $display("FAIL load4_load_cyc got=%b want=%b", got_v(), exp_v()); end
        advance();
        total++; if (o_cur !== 8'd4) begin bad++; $display("FAIL load4_at_wrap got=%0d want=4", o_cur); end
        total++; if (got_v() !== exp_v()) begin bad++; $display("FAIL load4_wrap_cyc got=%b want=%b", got_v(), exp_v()); end
        advance();
        total++; if (o_tick !== 1'b1) begin bad++; $display("FAIL load4_old_period_len3 got=%b want=1", o_tick); end
        for (int p = 0; p < 2; p++) begin
            measure_period(cyc, hi);
            total++; if (cyc != 4) begin bad++; $display("FAIL load4_period got=%0d want=4", cyc); end
            total++; if (hi != 4)  begin bad++; $display("FAIL load4_high_halves got=%0d want=4", hi); end
        end
    endtask

    task automatic test_bad_div();
        int cyc;
        int hi;
        for (int k = 0; k < 2; k++) begin
            div = (k == 0) ? 8'd1 : 8'd0;
            div_load = 1'b1;
            advance();
            div_load = 1'b0;
            total++; if (o_err !== 1'b1) begin bad++; $display("FAIL bad_div%0d_err got=%b want=1", k, o_err); end
            total++; if (got_v() !== exp_v()) begin bad++; $display("FAIL bad_div%0d_cyc got=%b want=%b", k, got_v(), exp_v()); end
            advance();
            total++; if (o_err !== 1'b0) begin bad++; $display("FAIL bad_div%0d_err_clear got=%b want=0", k, o_err); end
        end
        for (int i = 0; i < 10 && !o_tick; i++) advance();
        measure_period(cyc, hi);
        total++; if (cyc != 4) begin bad++; $display("FAIL bad_div_period got=%0d want=4", cyc); end
        total++; if (o_cur !== 8'd4) begin bad++; $display("FAIL bad_div_cur got=%0d want=4", o_cur); end
    endtask

    task automatic test_max_div();
        int cyc;
        int hi;
        div = 8'd255; div_load = 1'b1;
        advance();
        div_load = 1'b0;
        for (int i = 0; i < 20 && !(o_tick && o_cur == 8'd255); i++) advance();
        total++; if (o_cur !== 8'd255) begin bad++; $display("FAIL max_cur got=%0d want=255", o_cur); end
        div = 8'd2; div_load = 1'b1;
        measure_period(cyc, hi);
        div_load = 1'b0;
        total++; if (cyc != 255) begin bad++; $display("FAIL max_period got=%0d want=255", cyc); end
        total++; if (hi != 255)  begin bad++; $display("FAIL max_high_halves got=%0d want=255", hi); end
        total++; if (o_cur !== 8'd2) begin bad++; $display("FAIL max_then2_cur got=%0d want=2", o_cur); end
        measure_period(cyc, hi);
        total++; if (cyc != 2) begin bad++; $display("FAIL div2_period got=%0d want=2", cyc); end
        total++; if (hi != 2)  begin bad++; $display("FAIL div2_high_halves got=%0d want=2", hi); end
    endtask

    task automatic test_stop_restart();
        int n;
        div = 8'd5; div_load = 1'b1;
        advance();
        div_load = 1'b0;
        for (int i = 0; i < 20 && !(o_tick && o_cur == 8'd5); i++) advance();
        en = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && o_run; i++) begin
            advance();
            n++;
        end
        total++; if (n != 4) begin bad++; $display("FAIL stop_edges_after_tick got=%0d want=4", n); end
        for (int i = 0; i < 3; i++) begin
            advance();
            total++; if (got_v() !== exp_v() || o_clk_p || o_clk_n) begin bad++; $display("FAIL stop_idle got=%b want=%b", got_v(), exp_v()); end
        end
        en = 1'b1;
        advance();
        total++; if (o_run !== 1'b1 || o_tick !== 1'b0) begin bad++; $display("FAIL restart_run got=%b%b want=10", o_run, o_tick); end
        advance();
        total++; if (o_tick !== 1'b1) begin bad++; $display("FAIL restart_first_tick got=%b want=1", o_tick); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            div_load = ($urandom_range(0, 6) == 0);
            div      = 8'($urandom_range(0, 12));
            advance();
            total++; if (got_v() !== exp_v()) begin bad++; $display("FAIL random_cyc%0d got=%b want=%b", i, got_v(), exp_v()); end
        end
        div_load = 1'b0;
    endtask

    task automatic test_rst_mid_period();
        bit found;
        en = 1'b1;
        div = 8'd7; div_load = 1'b1;
        advance();
        div_load = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            advance();
            found = (o_cur == 8'd7) && o_clk_n;
        end
        total++; if (!found) begin bad++; $display("FAIL rst_mid_no_high_phase got=0 want=1"); end
        rst = 1'b1;
        #1;
        total++; if (clk_o !== 1'b0)   begin bad++; $display("FAIL rst_mid_clk_o got=%b want=0", clk_o); end
        total++; if (tick !== 1'b0)    begin bad++; $display("FAIL rst_mid_tick got=%b want=0", tick); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL rst_mid_running got=%b want=0", running); end
        total++; if (cur_div !== 8'd3) begin bad++; $display("FAIL rst_mid_cur_div got=%0d want=3", cur_div); end
        m_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        advance();
        advance();
        total++; if (got_v() !== exp_v()) begin bad++; $display("FAIL rst_mid_resume got=%b want=%b", got_v(), exp_v()); end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_load_mid_period();
        test_bad_div();
        test_max_div();
        test_stop_restart();
        test_random();
        test_rst_mid_period();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
